// File: rtl/uart_tx_param.sv
// uart_tx_param: register-mapped UART transmitter with programmable baud
// divisor, transmit FIFO, configurable parity / stop length and a maskable
// interrupt. The serial output idles high and drives the pad directly.
module uart_tx_param #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int RESET_DIV  = 26
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wren,
  input  logic       rden,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       txout,
  output logic       irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = DIV_W + 1;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Programmable registers
  logic [DIV_W-1:0]  div_reg;
  logic [1:0]        parity_cfg_reg;
  logic              stop2_cfg_reg;
  logic              irq_en_reg;
  logic              tx_en_reg;
  logic              done_reg;
  logic              ovf_reg;

  // Transmit FIFO
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;

  // Frame engine
  logic [2:0]        state_reg;
  logic [CW-1:0]     baud_cnt_reg;
  logic [2:0]        bit_idx_reg;
  logic [DATA_W-1:0] shift_reg;
  logic              par_en_reg;
  logic              par_bit_reg;
  logic              stop2_reg;

  // Decoded strobes and helpers
  logic              wr_divl;
  logic              wr_txdata;
  logic              wr_divh;
  logic              wr_status;
  logic              wr_config;
  logic              fifo_nonempty;
  logic              fifo_full;
  logic              start_frame;
  logic              push_ok;
  logic              bit_end;
  logic              done_set;
  logic              busy;
  logic [DIV_W-1:0]  d_eff;
  logic [CW-1:0]     bit_load;
  logic [CW-1:0]     stop_load;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W:0]   par_chain;
  logic [8:0]        count_ext;
  logic [7:0]        level;
  logic [15:0]       div_ext;

  assign wr_divl   = wren && (addr == 3'd0);
  assign wr_txdata = wren && (addr == 3'd1);
  assign wr_divh   = wren && (addr == 3'd2);
  assign wr_status = wren && (addr == 3'd3);
  assign wr_config = wren && (addr == 3'd4);

  assign fifo_nonempty = (count_reg != '0);
  assign fifo_full     = (count_reg == DEPTH_V);
  assign bit_end       = (baud_cnt_reg == '0);
  assign busy          = (state_reg != ST_IDLE);

  // A new frame starts from idle, or straight out of the final stop cycle
  // so queued bytes go out back-to-back.
  assign start_frame = tx_en_reg && fifo_nonempty &&
                       ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && bit_end));

  // A full FIFO still accepts a write when a pop frees a slot that cycle.
  assign push_ok  = wr_txdata && (!fifo_full || start_frame);
  assign done_set = (state_reg == ST_STOP) && bit_end;

  // Divisor 0 behaves as 1; the counter runs from D-1 down to 0.
  assign d_eff     = (div_reg == '0) ? DIV_W'(1) : div_reg;
  assign bit_load  = {1'b0, d_eff} - CW'(1);
  assign stop_load = stop2_reg ? ({d_eff, 1'b0} - CW'(1)) : bit_load;

  assign head_data = fifo_mem[rd_ptr_reg];

  // Parity of the byte about to be popped, built as an XOR chain.
  assign par_chain[0] = 1'b0;
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_par
      assign par_chain[gi+1] = par_chain[gi] ^ head_data[gi];
    end
  endgenerate

  // FIFO storage: no reset so it maps onto RAM; read happens on pop.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= din[DATA_W-1:0];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (start_frame) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (push_ok && !start_frame) begin
        count_reg <= count_reg + (AW+1)'(1);
      end else if (!push_ok && start_frame) begin
        count_reg <= count_reg - (AW+1)'(1);
      end
    end
  end

  // Register writes and sticky status bits (a set beats a same-cycle clear).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_reg        <= DIV_W'(RESET_DIV);
      parity_cfg_reg <= 2'b00;
      stop2_cfg_reg  <= 1'b0;
      irq_en_reg     <= 1'b0;
      tx_en_reg      <= 1'b1;
      done_reg       <= 1'b0;
      ovf_reg        <= 1'b0;
    end else begin
      if (wr_divl) begin
        div_reg[7:0] <= din;
      end
      if (wr_divh) begin
        div_reg[DIV_W-1:8] <= din[DIV_W-9:0];
      end
      if (wr_config) begin
        parity_cfg_reg <= din[1:0];
        stop2_cfg_reg  <= din[2];
        irq_en_reg     <= din[3];
        tx_en_reg      <= din[4];
      end
      done_reg <= done_set | (done_reg & ~wr_status);
      ovf_reg  <= (wr_txdata & ~push_ok) | (ovf_reg & ~wr_status);
    end
  end

  // Frame sequencer: start, data LSB first, optional parity, stop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      par_en_reg   <= 1'b0;
      par_bit_reg  <= 1'b0;
      stop2_reg    <= 1'b0;
    end else if (start_frame) begin
      // Frame format is frozen here so later CONFIG writes only affect
      // subsequent frames.
      state_reg    <= ST_START;
      baud_cnt_reg <= bit_load;
      bit_idx_reg  <= '0;
      shift_reg    <= head_data;
      par_en_reg   <= (parity_cfg_reg == 2'b01) || (parity_cfg_reg == 2'b10);
      par_bit_reg  <= par_chain[DATA_W] ^ (parity_cfg_reg == 2'b10);
      stop2_reg    <= stop2_cfg_reg;
    end else begin
      case (state_reg)
        ST_START: begin
          if (bit_end) begin
            state_reg    <= ST_DATA;
            baud_cnt_reg <= bit_load;
          end else begin
            baud_cnt_reg <= baud_cnt_reg - CW'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx_reg == 3'(DATA_W-1)) begin
              state_reg    <= par_en_reg ? ST_PARITY : ST_STOP;
              baud_cnt_reg <= par_en_reg ? bit_load : stop_load;
            end else begin
              bit_idx_reg  <= bit_idx_reg + 3'd1;
              shift_reg    <= shift_reg >> 1;
              baud_cnt_reg <= bit_load;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg - CW'(1);
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state_reg    <= ST_STOP;
            baud_cnt_reg <= stop_load;
          end else begin
            baud_cnt_reg <= baud_cnt_reg - CW'(1);
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            state_reg <= ST_IDLE;
          end else begin
            baud_cnt_reg <= baud_cnt_reg - CW'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Line level follows the sequencer state; reset forces idle high at once.
  always_comb begin
    txout = 1'b1;
    case (state_reg)
      ST_START:  txout = 1'b0;
      ST_DATA:   txout = shift_reg[0];
      ST_PARITY: txout = par_bit_reg;
      default:   txout = 1'b1;
    endcase
  end

  assign irq = irq_en_reg & (done_reg | ovf_reg);

  assign count_ext = 9'(count_reg);
  assign level     = count_ext[8] ? 8'hFF : count_ext[7:0];
  assign div_ext   = 16'(div_reg);

  // Read mux; output is zero whenever no read is strobed.
  always_comb begin
    dout = 8'h00;
    if (rden) begin
      case (addr)
        3'd0:    dout = div_ext[7:0];
        3'd2:    dout = div_ext[15:8];
        3'd3:    dout = {3'b000, ovf_reg, busy, ~fifo_nonempty, done_reg, fifo_full};
        3'd4:    dout = {3'b000, tx_en_reg, irq_en_reg, stop2_cfg_reg, parity_cfg_reg};
        3'd5:    dout = level;
        default: dout = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Testbench for uart_tx_param: register table checks plus a byte
// scoreboard that is compared cycle by cycle against the serial line.
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wren = 1'b0;
  logic       rden = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       txout;
  logic       irq;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] sb_q[$];

  typedef struct {
    logic [2:0] a;
    logic [7:0] exp;
  } rd_vec_t;

  typedef struct {
    logic [7:0] data;
    logic [7:0] cfg;
  } frame_vec_t;

  always #5 clk = ~clk;

  uart_tx_param #(
    .DATA_W(8), .FIFO_DEPTH(16), .DIV_W(16), .RESET_DIV(26)
  ) dut (
    .clk(clk), .reset_n(reset_n), .wren(wren), .rden(rden), .addr(addr),
    .din(din), .dout(dout), .txout(txout), .irq(irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    wren = 1'b1; addr = a; din = d;
    @(posedge clk);
    #1;
    wren = 1'b0;
    $display("wr addr=%0d data=0x%02h", a, d);
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    @(posedge clk);
    #1;
    rden = 1'b1; addr = a;
    @(negedge clk);
    d = dout;
    rden = 1'b0;
    $display("rd addr=%0d data=0x%02h", a, d);
  endtask

  // Pops the next expected byte and checks every cycle of its frame.
  // Segments at index >= switch_seg use d_late cycles instead of d.
  task automatic check_frame(input int d, input int d_late, input int switch_seg,
                             input logic [1:0] par, input logic stop2,
                             input int budget, input logic mon);
    logic [7:0] data;
    logic       found;
    logic       first;
    logic       seg_val [11];
    int         seg_len [11];
    int         nseg;
    int         bad;
    int         busy_bad;
    if (sb_q.size() == 0) begin
      chk("scoreboard_underflow", 1, 0);
      return;
    end
    data = sb_q.pop_front();
    seg_val[0] = 1'b0;
    nseg = 1;
    for (int b = 0; b < 8; b++) begin
      seg_val[nseg] = data[b];
      nseg++;
    end
    if (par == 2'b01) begin
      seg_val[nseg] = ^data;
      nseg++;
    end else if (par == 2'b10) begin
      seg_val[nseg] = ~^data;
      nseg++;
    end
    seg_val[nseg] = 1'b1;
    nseg++;
    for (int s = 0; s < nseg; s++) begin
      seg_len[s] = (s >= switch_seg) ? d_late : d;
      if (s == nseg - 1 && stop2) seg_len[s] = seg_len[s] * 2;
    end
    if (mon) begin
      addr = 3'd3;
      rden = 1'b1;
    end
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (txout === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      chk($sformatf("frame_start 0x%02h", data), 0, 1);
      rden = 1'b0;
      return;
    end
    bad = 0;
    busy_bad = 0;
    first = 1'b1;
    for (int s = 0; s < nseg; s++) begin
      for (int k = 0; k < seg_len[s]; k++) begin
        if (!first) @(negedge clk);
        first = 1'b0;
        if (txout !== seg_val[s]) bad++;
        if (mon && dout[3] !== 1'b1) busy_bad++;
      end
    end
    chk($sformatf("frame 0x%02h bad_cycles", data), bad, 0);
    if (mon) chk($sformatf("busy 0x%02h low_cycles", data), busy_bad, 0);
    rden = 1'b0;
    $display("frame data=0x%02h par=%0d stop2=%0d bad_cycles=%0d", data, par, stop2, bad);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_vec_t    rv [6];
    frame_vec_t fv [6];
    logic [7:0] r;
    logic [7:0] b;
    int         ones;

    rv[0] = '{3'd0, 8'h1A};
    rv[1] = '{3'd1, 8'h00};
    rv[2] = '{3'd2, 8'h00};
    rv[3] = '{3'd3, 8'h04};
    rv[4] = '{3'd4, 8'h10};
    rv[5] = '{3'd5, 8'h00};

    fv[0] = '{8'hA5, 8'h18};   // no parity, irq enabled
    fv[1] = '{8'hA5, 8'h19};   // even parity -> 0
    fv[2] = '{8'hA5, 8'h1A};   // odd parity -> 1
    fv[3] = '{8'hA5, 8'h14};   // two stop bits
    fv[4] = '{8'h3C, 8'h1B};   // parity code 11 behaves as none
    fv[5] = '{8'h01, 8'h1E};   // odd parity, two stop bits, irq enabled

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_txout", txout, 1);
    chk("reset_irq", irq, 0);
    chk("reset_dout", dout, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      rd(rv[i].a, r);
      chk($sformatf("reset_reg%0d", rv[i].a), r, rv[i].exp);
    end
    @(posedge clk);
    #1;
    addr = 3'd4;
    rden = 1'b0;
    @(negedge clk);
    chk("dout_no_rden", dout, 0);

    // Single frames with different formats, divisor 4
    wr(3'd0, 8'd4);
    wr(3'd2, 8'd0);
    for (int i = 0; i < 6; i++) begin
      wr(3'd4, fv[i].cfg);
      rd(3'd4, r);
      chk("config_rb", r, {3'b000, fv[i].cfg[4:0]});
      sb_q.push_back(fv[i].data);
      wr(3'd1, fv[i].data);
      check_frame(4, 4, 99, fv[i].cfg[1:0], fv[i].cfg[2], 50, 1'b1);
      rd(3'd3, r);
      chk("status_done", r, 8'h06);
      chk("irq_after_frame", irq, fv[i].cfg[3]);
      wr(3'd3, 8'h00);
      rd(3'd3, r);
      chk("status_cleared", r, 8'h04);
      chk("irq_cleared", irq, 0);
    end

    // Overflow with tx disabled, then a back-to-back burst, divisor 2
    wr(3'd0, 8'd2);
    wr(3'd4, 8'h00);
    for (int i = 0; i < 17; i++) begin
      b = 8'(i * 29 + 17);
      if (i < 16) sb_q.push_back(b);
      wr(3'd1, b);
    end
    rd(3'd5, r);
    chk("level_full", r, 8'd16);
    rd(3'd3, r);
    chk("status_full_ovf", r, 8'h11);
    wr(3'd4, 8'h10);
    for (int i = 0; i < 16; i++) begin
      check_frame(2, 2, 99, 2'b00, 1'b0, (i == 0) ? 50 : 1, 1'b1);
    end
    rd(3'd3, r);
    chk("status_after_burst", r, 8'h16);
    ones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (txout === 1'b1) ones++;
    end
    chk("no_17th_frame", ones, 40);
    rd(3'd5, r);
    chk("level_after_burst", r, 8'd0);
    wr(3'd3, 8'h00);

    // Divisor change during bit 2 takes effect from bit 3
    wr(3'd0, 8'd3);
    sb_q.push_back(8'h0F);
    wr(3'd1, 8'h0F);
    fork
      check_frame(3, 6, 4, 2'b00, 1'b0, 50, 1'b0);
      begin
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (txout === 1'b0) break;
        end
        repeat (9) @(posedge clk);
        wr(3'd0, 8'd6);
      end
    join
    rd(3'd0, r);
    chk("divl_new", r, 8'd6);

    // Reset during bit 4 of a queued burst, divisor 4
    wr(3'd0, 8'd4);
    wr(3'd3, 8'h00);
    for (int i = 0; i < 3; i++) wr(3'd1, 8'h0F);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (txout === 1'b0) break;
    end
    repeat (22) @(negedge clk);
    chk("bit4_before_reset", txout, 0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("txout_on_reset", txout, 1);
    @(negedge clk);
    reset_n = 1'b1;
    sb_q.delete();
    rd(3'd3, r);
    chk("status_after_reset", r, 8'h04);
    rd(3'd5, r);
    chk("level_after_reset", r, 8'd0);
    rd(3'd0, r);
    chk("divl_after_reset", r, 8'h1A);
    rd(3'd4, r);
    chk("config_after_reset", r, 8'h10);
    ones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (txout === 1'b1) ones++;
    end
    chk("idle_after_reset", ones, 20);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
